alu_op_control_unit: RTL
========================

// Module: alu_op_control_unit
// PURPOSE
//  Parametrised control sequencer for the bus datapath: a Moore FSM that fetches one instruction and runs
//  register-to-register ALU, unary and two-result (mul/div) ops, replacing hand-stepped T0..T5 sequences.
//  Drives the datapath's register in/out strobes, MAR/MDR/IR/Y/Z/PC controls and the ALU operation code.
//  Sits beside the bus module, driven from the same clock.
// PARAMETERS
//  NUM_REGS   16  general registers; width of Rin/Rout one-hot vectors
//  REG_IDX_W  4   width of each IR register field
//  OP_W       5   opcode width, IR[31:32-OP_W]
//  MEM_WAIT   0   extra cycles T1 is held for memory read (0..15)
// PORTS
//  clock     in   1         rising-edge clock
//  clear     in   1         asynchronous active-high reset
//  run       in   1         start request, sampled in IDLE/DONE
//  ir        in   32        IR register contents from the datapath (valid from T3)
//  PCout, MARin, IncPC, PCin, read, MDRin, MDRout, IRin, Yin  out 1  datapath strobes
//  Zhighin, Zlowin, ZHIout, ZLOout, HIin, LOin                 out 1  Z/HI/LO strobes
//  Rin, Rout out  NUM_REGS  one-hot register load / drive strobes
//  operation out  OP_W      ALU opcode, equal to IR opcode during execute
//  busy      out  1         high in every state except IDLE
//  done      out  1         one-cycle pulse: instruction retired
//  illegal   out  1         one-cycle pulse: unsupported opcode or register index >= NUM_REGS
// BEHAVIOUR
//  Reset: clear=1 immediately forces state IDLE, wait counter 0, every output 0, including mid-instruction.
//  Outputs decoded from registered state only: each strobe high for the whole state cycle.
//  Datapath latches on the rising edge that ends the state.
//  Fetch (all classes):
//   T0: PCout, MARin, IncPC, Zlowin.
//   T1: ZLOout, PCin, read, MDRin; held 1+MEM_WAIT cycles via down-counter.
//   T2: MDRout, IRin.
//  Fields: op=IR[31:27], ra=IR[26:23], rb=IR[22:19], rc=IR[18:15].
//  Classes (decoded in T3; operation=op from T3 until the last state):
//   binary 00011..01011 (add,sub,and,or,shr,shra,shl,ror,rol):
//    T3 Rout[rb],Yin; T4 Rout[rc],Zlowin; T5 ZLOout,Rin[ra].
//   mul 01111 / div 10000:
//    T3 Rout[rb],Yin; T4 Rout[rc],Zhighin,Zlowin; T5 ZHIout,HIin; T6 ZLOout,LOin.
//   unary neg 10001 / not 10010:
//    T3 Rout[rb],Zlowin; T4 ZLOout,Rin[ra].
//   anything else, or any used index >= NUM_REGS:
//    T3 drives no strobes, pulses illegal, next state IDLE.
//  Latency with MEM_WAIT=0, counted from run sampled high to done:
//   binary 7 cycles; unary 6; mul/div 8. Add MEM_WAIT to each.
//  DONE state: done=1 for one cycle; next state T0 if run=1 (back-to-back), else IDLE.
//  run is ignored while busy. Writes to R0 are allowed; ra==rb is legal.
//  Rin/Rout are strictly one-hot or zero; Rin and Rout are never high in the same cycle.
// STRUCTURE
//  Shared include control_defs.vh: opcode localparams, state encoding, class codes.
//  Sub-module alu_instr_decode (combinational): ir -> class, ra/rb/rc one-hot, idx_err.
//  Top module holds the FSM, wait counter and output decode.
// TESTING
//  1. R4=0x12, R5=0x14, ir=0x18228000 (add R0,R4,R5): strobes as listed per T-state; Rin[0] in T5;
//     done 7 cycles after run; R0=0x26.
//  2. ir=0x78228000 (mul R4,R5), R4=3, R5=-2: HIin in T5, LOin in T6; done at 8 cycles;
//     HI=0xFFFFFFFF, LO=0xFFFFFFFA.
//  3. ir=0x88A00000 (neg R1,R4), R4=0x12: Rin[1] in T4; done at 6 cycles; R1=0xFFFFFFEE.
//  4. ir=0x00000000 (ld, unsupported): illegal pulses in T3; no Rin/HIin/LOin ever high; back to IDLE.
//  5. MEM_WAIT=2, add as test 1: read/MDRin high for 3 consecutive cycles; done at 9 cycles.
//     run held high: second instruction's T0 follows DONE directly.
//  6. clear asserted mid-T4 of test 1: all outputs 0 before the next edge; R0 unchanged; busy=0;
//     run after release restarts from T0.

Source files
------------

// File: rtl/alu_op_control_unit_pkg.sv
// rtl/alu_op_control_unit_pkg.sv - shared state, class and opcode definitions for the ALU op sequencer
//
// Purpose: state encoding, instruction class codes, opcode values and the
//          opcode-to-class helper used by the decoder and the FSM.
package alu_op_control_unit_pkg;

    // Opcode values (5-bit field; wider OP_W zero-extends)
    localparam int unsigned OP_ADD = 32'd3;   // first binary op
    localparam int unsigned OP_ROL = 32'd11;  // last binary op
    localparam int unsigned OP_MUL = 32'd15;
    localparam int unsigned OP_DIV = 32'd16;
    localparam int unsigned OP_NEG = 32'd17;
    localparam int unsigned OP_NOT = 32'd18;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_DONE = 4'd8
    } state_e;

    typedef enum logic [1:0] {
        CLS_BINARY  = 2'd0,
        CLS_MULDIV  = 2'd1,
        CLS_UNARY   = 2'd2,
        CLS_ILLEGAL = 2'd3
    } class_e;

    function automatic class_e classify(input logic [31:0] op);
        class_e c;
        if (op >= OP_ADD && op <= OP_ROL) begin
            c = CLS_BINARY;
        end else if (op == OP_MUL || op == OP_DIV) begin
            c = CLS_MULDIV;
        end else if (op == OP_NEG || op == OP_NOT) begin
            c = CLS_UNARY;
        end else begin
            c = CLS_ILLEGAL;
        end
        return c;
    endfunction

endpackage

// File: rtl/alu_op_control_unit_decode.sv
// rtl/alu_op_control_unit_decode.sv - combinational IR field decoder for the ALU op sequencer
//
// Purpose: split IR into opcode and register fields, classify the opcode and
//          produce one-hot register selects. An out-of-range register index
//          used by the instruction's class demotes the class to illegal.
// Ports:
//   ir     in   32        instruction register contents
//   op     out  OP_W      opcode field IR[31 -: OP_W]
//   cls    out  class_e   instruction class (illegal on bad opcode or index)
//   ra_oh  out  NUM_REGS  one-hot ra (zero if out of range)
//   rb_oh  out  NUM_REGS  one-hot rb (zero if out of range)
//   rc_oh  out  NUM_REGS  one-hot rc (zero if out of range)
module alu_op_control_unit_decode
    import alu_op_control_unit_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4,
    parameter int OP_W      = 5
) (
    input  logic [31:0]         ir,
    output logic [OP_W-1:0]     op,
    output class_e              cls,
    output logic [NUM_REGS-1:0] ra_oh,
    output logic [NUM_REGS-1:0] rb_oh,
    output logic [NUM_REGS-1:0] rc_oh
);

    localparam int RA_MSB = 31 - OP_W;
    localparam int RB_MSB = RA_MSB - REG_IDX_W;
    localparam int RC_MSB = RB_MSB - REG_IDX_W;
    localparam int RC_LSB = RC_MSB - REG_IDX_W + 1;

    logic [REG_IDX_W-1:0] ra;
    logic [REG_IDX_W-1:0] rb;
    logic [REG_IDX_W-1:0] rc;
    logic                 ra_ok;
    logic                 rb_ok;
    logic                 rc_ok;
    logic                 idx_err;
    class_e               base_cls;
    logic                 unused_low;

    assign op = ir[31 -: OP_W];
    assign ra = ir[RA_MSB -: REG_IDX_W];
    assign rb = ir[RB_MSB -: REG_IDX_W];
    assign rc = ir[RC_MSB -: REG_IDX_W];

    // Bits below rc carry no meaning for this instruction set
    assign unused_low = ^ir[RC_LSB-1:0];

    assign ra_ok = 32'(ra) < 32'(NUM_REGS);
    assign rb_ok = 32'(rb) < 32'(NUM_REGS);
    assign rc_ok = 32'(rc) < 32'(NUM_REGS);

    assign ra_oh = ra_ok ? (NUM_REGS'(1) << ra) : '0;
    assign rb_oh = rb_ok ? (NUM_REGS'(1) << rb) : '0;
    assign rc_oh = rc_ok ? (NUM_REGS'(1) << rc) : '0;

    assign base_cls = classify(32'(op));

    // Only the fields a class actually uses can make it illegal
    always_comb begin
        idx_err = 1'b0;
        case (base_cls)
            CLS_BINARY: idx_err = !(ra_ok && rb_ok && rc_ok);
            CLS_MULDIV: idx_err = !(rb_ok && rc_ok);
            CLS_UNARY:  idx_err = !(ra_ok && rb_ok);
            default:    idx_err = 1'b0;
        endcase
    end

    assign cls = idx_err ? CLS_ILLEGAL : base_cls;

endmodule

// File: rtl/alu_op_control_unit.sv
// rtl/alu_op_control_unit.sv - Moore control sequencer for fetch and ALU register ops
//
// Purpose: fetches one instruction (T0..T2, T1 stretched by MEM_WAIT) and runs
//          binary, unary and two-result mul/div ops, driving datapath strobes.
// Ports:
//   clock, clear (async active-high), run        inputs
//   ir [31:0]                                    IR contents, valid from T3
//   PCout MARin IncPC PCin read MDRin MDRout IRin Yin              strobes
//   Zhighin Zlowin ZHIout ZLOout HIin LOin                          Z/HI/LO strobes
//   Rin/Rout [NUM_REGS-1:0]                      one-hot register strobes
//   operation [OP_W-1:0]                         ALU opcode during execute
//   busy, done, illegal                          status
module alu_op_control_unit
    import alu_op_control_unit_pkg::*;
#(
    parameter int NUM_REGS  = 16,
    parameter int REG_IDX_W = 4,
    parameter int OP_W      = 5,
    parameter int MEM_WAIT  = 0
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [31:0]         ir,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                PCin,
    output logic                read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Yin,
    output logic                Zhighin,
    output logic                Zlowin,
    output logic                ZHIout,
    output logic                ZLOout,
    output logic                HIin,
    output logic                LOin,
    output logic [NUM_REGS-1:0] Rin,
    output logic [NUM_REGS-1:0] Rout,
    output logic [OP_W-1:0]     operation,
    output logic                busy,
    output logic                done,
    output logic                illegal
);

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

    state_e              state_q;
    logic [3:0]          wait_q;
    logic [OP_W-1:0]     op;
    class_e              cls;
    logic [NUM_REGS-1:0] ra_oh;
    logic [NUM_REGS-1:0] rb_oh;
    logic [NUM_REGS-1:0] rc_oh;

    // IR is a datapath register held from T3 to the end of the instruction,
    // so decoding it live is stable across every execute state.
    alu_op_control_unit_decode #(
        .NUM_REGS  (NUM_REGS),
        .REG_IDX_W (REG_IDX_W),
        .OP_W      (OP_W)
    ) u_decode (
        .ir    (ir),
        .op    (op),
        .cls   (cls),
        .ra_oh (ra_oh),
        .rb_oh (rb_oh),
        .rc_oh (rc_oh)
    );

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= ST_IDLE;
            wait_q  <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (run) begin
                        state_q <= ST_T0;
                    end
                end
                ST_T0: begin
                    state_q <= ST_T1;
                    wait_q  <= WAIT_INIT;
                end
                ST_T1: begin
                    // T1 lasts 1+MEM_WAIT cycles
                    if (wait_q == 4'd0) begin
                        state_q <= ST_T2;
                    end else begin
                        wait_q <= wait_q - 4'd1;
                    end
                end
                ST_T2: state_q <= ST_T3;
                ST_T3: state_q <= (cls == CLS_ILLEGAL) ? ST_IDLE : ST_T4;
                ST_T4: state_q <= (cls == CLS_UNARY) ? ST_DONE : ST_T5;
                ST_T5: state_q <= (cls == CLS_MULDIV) ? ST_T6 : ST_DONE;
                ST_T6: state_q <= ST_DONE;
                ST_DONE: state_q <= run ? ST_T0 : ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        PCout     = 1'b0;
        MARin     = 1'b0;
        IncPC     = 1'b0;
        PCin      = 1'b0;
        read      = 1'b0;
        MDRin     = 1'b0;
        MDRout    = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Zhighin   = 1'b0;
        Zlowin    = 1'b0;
        ZHIout    = 1'b0;
        ZLOout    = 1'b0;
        HIin      = 1'b0;
        LOin      = 1'b0;
        Rin       = '0;
        Rout      = '0;
        operation = '0;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;
        illegal   = 1'b0;
        case (state_q)
            ST_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            ST_T1: begin
                ZLOout = 1'b1;
                PCin   = 1'b1;
                read   = 1'b1;
                MDRin  = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            ST_T3: begin
                operation = op;
                case (cls)
                    CLS_BINARY, CLS_MULDIV: begin
                        Rout = rb_oh;
                        Yin  = 1'b1;
                    end
                    CLS_UNARY: begin
                        Rout   = rb_oh;
                        Zlowin = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            ST_T4: begin
                operation = op;
                case (cls)
                    CLS_BINARY: begin
                        Rout   = rc_oh;
                        Zlowin = 1'b1;
                    end
                    CLS_MULDIV: begin
                        Rout    = rc_oh;
                        Zhighin = 1'b1;
                        Zlowin  = 1'b1;
                    end
                    CLS_UNARY: begin
                        ZLOout = 1'b1;
                        Rin    = ra_oh;
                    end
                    default: operation = op;
                endcase
            end
            ST_T5: begin
                operation = op;
                if (cls == CLS_MULDIV) begin
                    ZHIout = 1'b1;
                    HIin   = 1'b1;
                end else begin
                    ZLOout = 1'b1;
                    Rin    = ra_oh;
                end
            end
            ST_T6: begin
                operation = op;
                ZLOout    = 1'b1;
                LOin      = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: busy = (state_q != ST_IDLE);
        endcase
    end

endmodule
